// File: rtl/bayer_mosaic_tx_if.sv
// Bayer transmit stream bundle.
// Upstream side : iValid, iR, iG, iB in; oReady out (RGB pixel handshake).
// Downstream side: oValid, oData, oNewFrame, oDone, oXCnt, oYCnt out; iReady in.
// master = the transmitter block, slave = the environment around it.
interface bayer_mosaic_tx_if;
  logic        iValid;
  logic [7:0]  iR;
  logic [7:0]  iG;
  logic [7:0]  iB;
  logic        oReady;
  logic        oValid;
  logic [7:0]  oData;
  logic        iReady;
  logic        oNewFrame;
  logic        oDone;
  logic [31:0] oXCnt;
  logic [31:0] oYCnt;

  modport master (
    input  iValid, iR, iG, iB, iReady,
    output oReady, oValid, oData, oNewFrame, oDone, oXCnt, oYCnt
  );

  modport slave (
    output iValid, iR, iG, iB, iReady,
    input  oReady, oValid, oData, oNewFrame, oDone, oXCnt, oYCnt
  );
endinterface

// File: rtl/bayer_mosaic_tx.sv
// Bayer mosaic transmitter: takes full-RGB pixels in raster order and emits one
// 8-bit CFA sample per pixel, with a programmable blanking gap between frames.
// Ports: clk, reset (sync, active-high), bus (bayer_mosaic_tx_if.master):
//   iValid/iR/iG/iB/oReady  upstream RGB handshake (oReady is combinational)
//   oValid/oData/iReady     downstream Bayer sample handshake, 1-cycle latency
//   oNewFrame/oXCnt/oYCnt   position tags registered with the sample
//   oDone                   1-cycle pulse after the frame's last sample leaves
module bayer_mosaic_tx #(
  parameter int unsigned width    = 320,
  parameter int unsigned height   = 240,
  parameter int unsigned pattern  = 0,
  parameter int unsigned frameGap = 16
) (
  input  logic               clk,
  input  logic               reset,
  bayer_mosaic_tx_if.master  bus
);

  localparam int unsigned CntW = 32;
  localparam logic [1:0]      cfaPat  = 2'(pattern);
  localparam logic [CntW-1:0] lastCol = CntW'(width - 1);
  localparam logic [CntW-1:0] lastRow = CntW'(height - 1);
  localparam logic [CntW-1:0] lastGap = CntW'(frameGap - 1);

  typedef enum logic {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [CntW-1:0] blankCnt;
  logic [CntW-1:0] blankCntNext;
  logic [CntW-1:0] col;
  logic [CntW-1:0] row;
  logic            inXfer;
  logic            outXfer;
  logic            lastPix;
  logic [7:0]      sample;

  assign bus.oReady = (state == ACTIVE) && (!bus.oValid || bus.iReady);
  assign inXfer     = bus.iValid && bus.oReady;
  assign outXfer    = bus.oValid && bus.iReady;
  assign lastPix    = (col == lastCol) && (row == lastRow);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACTIVE;
      blankCnt <= '0;
    end else begin
      state    <= stateNext;
      blankCnt <= blankCntNext;
    end
  end

  // Next state: enter BLANK after the frame's last accept, stay frameGap cycles
  always_comb begin
    stateNext    = state;
    blankCntNext = blankCnt;
    case (state)
      ACTIVE: begin
        if (inXfer && lastPix && (frameGap != 0)) begin
          stateNext    = BLANK;
          blankCntNext = '0;
        end
      end
      BLANK: begin
        if (blankCnt == lastGap) begin
          stateNext    = ACTIVE;
          blankCntNext = '0;
        end else begin
          blankCntNext = blankCnt + CntW'(1);
        end
      end
      default: stateNext = ACTIVE;
    endcase
  end

  // CFA colour pick from (pattern, row parity, column parity); green otherwise
  always_comb begin
    sample = bus.iG;
    case ({cfaPat, row[0], col[0]})
      4'b00_00, 4'b01_01, 4'b10_10, 4'b11_11: sample = bus.iR;
      4'b00_11, 4'b01_10, 4'b10_01, 4'b11_00: sample = bus.iB;
      default:                                sample = bus.iG;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (inXfer) begin
      if (col == lastCol) begin
        col <= '0;
        row <= (row == lastRow) ? '0 : row + CntW'(1);
      end else begin
        col <= col + CntW'(1);
      end
    end
  end

  // One-deep output register; a simultaneous in/out transfer reloads it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.oValid    <= 1'b0;
      bus.oData     <= '0;
      bus.oNewFrame <= 1'b0;
      bus.oXCnt     <= '0;
      bus.oYCnt     <= '0;
      bus.oDone     <= 1'b0;
    end else begin
      bus.oDone <= outXfer && (bus.oXCnt == lastCol) && (bus.oYCnt == lastRow);
      if (inXfer) begin
        bus.oValid    <= 1'b1;
        bus.oData     <= sample;
        bus.oNewFrame <= (col == '0) && (row == '0);
        bus.oXCnt     <= col;
        bus.oYCnt     <= row;
      end else if (outXfer) begin
        bus.oValid    <= 1'b0;
        bus.oNewFrame <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Testbench for bayer_mosaic_tx: three instances (RGGB gap 3, BGGR gap 3,
// RGGB gap 0) on a 4x2 frame, one selected at a time; a negedge monitor runs a
// scoreboard of expected samples, plus oDone timing and stall-hold checks.
module tb_bayer_mosaic_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       drvValid = 1'b0;
  logic [7:0] drvR = '0, drvG = '0, drvB = '0;
  logic       drvReady = 1'b1;
  int         readyMode = 0;
  int         sel = 0;

  bayer_mosaic_tx_if if0 ();
  bayer_mosaic_tx_if if1 ();
  bayer_mosaic_tx_if if2 ();

  bayer_mosaic_tx #(.width(4), .height(2), .pattern(0), .frameGap(3))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  bayer_mosaic_tx #(.width(4), .height(2), .pattern(3), .frameGap(3))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  bayer_mosaic_tx #(.width(4), .height(2), .pattern(0), .frameGap(0))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.iValid = drvValid && (sel == 0);
  assign if1.iValid = drvValid && (sel == 1);
  assign if2.iValid = drvValid && (sel == 2);
  assign if0.iR = drvR; assign if0.iG = drvG; assign if0.iB = drvB;
  assign if1.iR = drvR; assign if1.iG = drvG; assign if1.iB = drvB;
  assign if2.iR = drvR; assign if2.iG = drvG; assign if2.iB = drvB;
  assign if0.iReady = drvReady;
  assign if1.iReady = drvReady;
  assign if2.iReady = drvReady;

  logic        obsReady, obsValid, obsNf, obsDone;
  logic [7:0]  obsData;
  logic [31:0] obsX, obsY;

  always_comb begin
    obsReady = if0.oReady; obsValid = if0.oValid; obsNf = if0.oNewFrame;
    obsDone  = if0.oDone;  obsData  = if0.oData;  obsX  = if0.oXCnt; obsY = if0.oYCnt;
    if (sel == 1) begin
      obsReady = if1.oReady; obsValid = if1.oValid; obsNf = if1.oNewFrame;
      obsDone  = if1.oDone;  obsData  = if1.oData;  obsX  = if1.oXCnt; obsY = if1.oYCnt;
    end else if (sel == 2) begin
      obsReady = if2.oReady; obsValid = if2.oValid; obsNf = if2.oNewFrame;
      obsDone  = if2.oDone;  obsData  = if2.oData;  obsX  = if2.oXCnt; obsY = if2.oYCnt;
    end
  end

  typedef struct {
    logic [7:0] r, g, b;
    int         x, y;
    logic       nf;
    logic [7:0] expRggb, expBggr;
  } vecT;

  typedef struct {
    logic [7:0] data;
    int         x, y;
    logic       nf;
  } expT;

  vecT  tbl[8];
  expT  sbq[$];
  expT  drvExp;
  int   checks = 0;
  int   errors = 0;
  int   popCnt = 0;
  int   doneCnt = 0;
  int   waitLog[64];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // iReady pattern: mode 0 always high, mode 1 repeats 1,0,0,1
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    drvReady = (readyMode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  // Monitor: scoreboard pop on out_xfer, push on in_xfer, oDone and stall checks
  expT         monE;
  logic        expDone = 1'b0;
  logic        stallPrev = 1'b0;
  logic [7:0]  prevData;
  logic [31:0] prevX, prevY;
  logic        prevNf;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      expDone   = 1'b0;
      stallPrev = 1'b0;
    end else begin
      if (expDone || obsDone) begin
        checks++;
        if (obsDone !== expDone) begin
          errors++;
          $display("FAIL oDone: got %0b, expected %0b", obsDone, expDone);
        end
      end
      if (obsDone) doneCnt++;
      expDone = 1'b0;
      if (stallPrev) begin
        checks++;
        if (!obsValid || obsData !== prevData || obsX !== prevX || obsY !== prevY || obsNf !== prevNf) begin
          errors++;
          $display("FAIL stallHold: got v=%0b d=%0d x=%0d y=%0d nf=%0b, expected v=1 d=%0d x=%0d y=%0d nf=%0b",
                   obsValid, obsData, obsX, obsY, obsNf, prevData, prevX, prevY, prevNf);
        end
      end
      if (obsValid && drvReady) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpectedSample: got d=%0d x=%0d y=%0d, expected none", obsData, obsX, obsY);
        end else begin
          monE = sbq.pop_front();
          popCnt++;
          if (obsData !== monE.data || obsX !== 32'(monE.x) || obsY !== 32'(monE.y) || obsNf !== monE.nf) begin
            errors++;
            $display("FAIL sample: got d=%0d x=%0d y=%0d nf=%0b, expected d=%0d x=%0d y=%0d nf=%0b",
                     obsData, obsX, obsY, obsNf, monE.data, monE.x, monE.y, monE.nf);
          end
          if (monE.x == 3 && monE.y == 1) expDone = 1'b1;
        end
      end
      if (drvValid && obsReady) sbq.push_back(drvExp);
      stallPrev = obsValid && !drvReady;
      prevData = obsData; prevX = obsX; prevY = obsY; prevNf = obsNf;
    end
  end

  // Drive n pixels in raster order from (0,0), logging the wait before each accept
  task automatic sendPixels(input int n);
    int  k;
    int  w;
    bit  got;
    for (int i = 0; i < n; i++) begin
      k = i % 8;
      drvValid = 1'b1;
      drvR = tbl[k].r; drvG = tbl[k].g; drvB = tbl[k].b;
      drvExp.data = (sel == 1) ? tbl[k].expBggr : tbl[k].expRggb;
      drvExp.x = tbl[k].x; drvExp.y = tbl[k].y; drvExp.nf = tbl[k].nf;
      w = 0; got = 1'b0;
      while (!got) begin
        @(negedge clk);
        if (obsReady) got = 1'b1;
        else begin
          w++;
          if (w > 200) begin
            chk("acceptTimeout", w, 0);
            got = 1'b1;
          end
        end
      end
      waitLog[i] = w;
      @(posedge clk); #1;
    end
    drvValid = 1'b0;
  endtask

  // Wait (bounded) for all expected samples to leave, then settle
  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("queueEmpty", sbq.size(), 0);
  endtask

  task automatic startTest(input int s, input int mode);
    sel = s; readyMode = mode;
    popCnt = 0; doneCnt = 0;
  endtask

  initial begin
    logic [7:0] eRggb[8];
    logic [7:0] eBggr[8];
    int         sumW;
    eRggb = '{8'd10, 8'd51, 8'd12, 8'd53, 8'd54, 8'd95, 8'd56, 8'd97};
    // BGGR: even rows B G B G, odd rows G R G R
    eBggr = '{8'd90, 8'd51, 8'd92, 8'd53, 8'd54, 8'd15, 8'd56, 8'd17};
    for (int i = 0; i < 8; i++) begin
      tbl[i].r = 8'(10 + i); tbl[i].g = 8'(50 + i); tbl[i].b = 8'(90 + i);
      tbl[i].x = i % 4; tbl[i].y = i / 4; tbl[i].nf = (i == 0);
      tbl[i].expRggb = eRggb[i]; tbl[i].expBggr = eBggr[i];
    end

    // Reset values on every instance
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rstValid", obsValid, 0);
      chk("rstData", obsData, 0);
      chk("rstNewFrame", obsNf, 0);
      chk("rstDone", obsDone, 0);
      chk("rstXY", {obsX, obsY}, 0);
      chk("rstReady", obsReady, 1);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // RGGB frame at full throughput
    startTest(0, 0);
    sendPixels(8);
    drain();
    chk("t1Pops", popCnt, 8);
    chk("t1Done", doneCnt, 1);
    sumW = 0;
    for (int i = 0; i < 8; i++) sumW += waitLog[i];
    chk("t1Waits", sumW, 0);

    // Two frames back to back: exactly frameGap blank cycles between them
    startTest(0, 0);
    sendPixels(16);
    drain();
    chk("t2Gap", waitLog[8], 3);
    sumW = 0;
    for (int i = 0; i < 16; i++) if (i != 8) sumW += waitLog[i];
    chk("t2OtherWaits", sumW, 0);
    chk("t2Pops", popCnt, 16);
    chk("t2Done", doneCnt, 2);

    // Downstream stalls 1,0,0,1
    startTest(0, 1);
    sendPixels(8);
    drain();
    chk("t3Pops", popCnt, 8);
    chk("t3Done", doneCnt, 1);
    readyMode = 0;

    // Reset mid-frame, then a full frame
    startTest(0, 0);
    sendPixels(5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("t5RstValid", obsValid, 0);
    chk("t5RstNewFrame", obsNf, 0);
    chk("t5RstDone", obsDone, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    popCnt = 0;
    sendPixels(8);
    drain();
    chk("t5Pops", popCnt, 8);
    chk("t5Done", doneCnt, 1);

    // BGGR instance
    startTest(1, 0);
    sendPixels(8);
    drain();
    chk("t4Pops", popCnt, 8);
    chk("t4Done", doneCnt, 1);

    // Zero frame gap: oReady never drops, oDone every 8 transfers
    startTest(2, 0);
    sendPixels(24);
    drain();
    sumW = 0;
    for (int i = 0; i < 24; i++) sumW += waitLog[i];
    chk("t6Waits", sumW, 0);
    chk("t6Pops", popCnt, 24);
    chk("t6Done", doneCnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
